// File: rtl/geofence_event_tracker.sv
// Debounced per-object inside/outside tracker fed round-robin by the geofence core,
// with a small enter/exit event FIFO drained by a valid/ready consumer.
module geofence_event_tracker #(
  parameter int NUM_OBJ    = 8,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       in_inside,
  output logic [$clog2(NUM_OBJ)-1:0] obj_idx,
  output logic [NUM_OBJ-1:0]         inside_map,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_OBJ)-1:0] evt_id,
  output logic                       evt_enter,
  output logic                       overflow
);

  localparam int IDX_W = $clog2(NUM_OBJ);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W:0] DEB_V  = (CNT_W+1)'(DEBOUNCE);
  localparam logic [CNT_W:0] ONE_V  = (CNT_W+1)'(1);
  localparam logic [PTR_W:0] FULL_V = (PTR_W+1)'(FIFO_DEPTH);

  logic [CNT_W-1:0] cnt [NUM_OBJ];
  logic [IDX_W-1:0] mem_id    [FIFO_DEPTH];
  logic             mem_enter [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  logic [CNT_W-1:0] sel_cnt;
  logic             sel_c, agree, reach, push, pop, full, accept;

  always_comb begin
    sel_cnt = cnt[obj_idx];
    sel_c   = inside_map[obj_idx];
    agree   = (in_inside == sel_c);
    reach   = (({1'b0, sel_cnt} + ONE_V) == DEB_V);
    push    = in_valid && !agree && reach;
    full    = (count == FULL_V);
    pop     = evt_valid && evt_ready;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    accept  = push && (!full || pop);
  end

  assign evt_valid = (count != '0);
  assign evt_id    = evt_valid ? mem_id[rd_ptr] : '0;
  assign evt_enter = evt_valid ? mem_enter[rd_ptr] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      obj_idx    <= '0;
      inside_map <= '0;
      for (int i = 0; i < NUM_OBJ; i++) cnt[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      if (in_valid) begin
        obj_idx <= obj_idx + IDX_W'(1);
        if (agree) begin
          cnt[obj_idx] <= '0;
        end else if (reach) begin
          inside_map[obj_idx] <= in_inside;
          cnt[obj_idx]        <= '0;
        end else begin
          cnt[obj_idx] <= sel_cnt + CNT_W'(1);
        end
      end
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
      if (push && !accept) overflow <= 1'b1;
    end
  end

  // Event storage carries data only; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem_id[wr_ptr]    <= obj_idx;
      mem_enter[wr_ptr] <= in_inside;
    end
  end

endmodule

// File: tb/tb_geofence_event_tracker.sv
// Bench for geofence_event_tracker: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_geofence_event_tracker;

  localparam int N   = 8;
  localparam int DEB = 3;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_inside = 1'b0;
  logic [2:0] obj_idx;
  logic [7:0] inside_map;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [2:0] evt_id;
  logic       evt_enter;
  logic       overflow;

  geofence_event_tracker #(.NUM_OBJ(N), .DEBOUNCE(DEB), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_inside(in_inside),
    .obj_idx(obj_idx), .inside_map(inside_map), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_id(evt_id), .evt_enter(evt_enter),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: confirmed state, disagreement counters, event queue.
  bit m_c   [N];
  int m_cnt [N];
  int m_idx;
  bit m_ovf;
  int qid [$];
  bit qen [$];

  // Consumer-side record of delivered events.
  int ids_seen [$];
  bit ens_seen [$];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin m_c[i] = 1'b0; m_cnt[i] = 0; end
      m_idx = 0; m_ovf = 1'b0;
      qid.delete(); qen.delete();
    end else begin
      if (evt_valid && evt_ready) begin
        ids_seen.push_back(int'(evt_id));
        ens_seen.push_back(evt_enter);
      end
      if (evt_ready && qid.size() > 0) begin
        void'(qid.pop_front());
        void'(qen.pop_front());
      end
      if (in_valid) begin
        if (in_inside == m_c[m_idx]) m_cnt[m_idx] = 0;
        else if (m_cnt[m_idx] + 1 == DEB) begin
          m_c[m_idx] = in_inside;
          m_cnt[m_idx] = 0;
          if (qid.size() < DEP) begin qid.push_back(m_idx); qen.push_back(in_inside); end
          else m_ovf = 1'b1;
        end else m_cnt[m_idx]++;
        m_idx = (m_idx + 1) % N;
      end
    end
  end

  function automatic logic [7:0] model_map();
    logic [7:0] m;
    for (int i = 0; i < N; i++) m[i] = m_c[i];
    return m;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("obj_idx", 32'(obj_idx), 32'(m_idx));
      chk("inside_map", 32'(inside_map), 32'(model_map()));
      chk("evt_valid", 32'(evt_valid), 32'(qid.size() > 0));
      chk("evt_id", 32'(evt_id), (qid.size() > 0) ? 32'(qid[0]) : 32'd0);
      chk("evt_enter", 32'(evt_enter), (qid.size() > 0) ? 32'(qen[0]) : 32'd0);
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic cyc(input logic r, input logic v, input logic ins, input logic rdy);
    reset = r; in_valid = v; in_inside = ins; evt_ready = rdy;
    @(negedge clk);
  endtask

  task automatic round(input logic [7:0] mask, input logic rdy);
    for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, mask[k], rdy);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    ids_seen.delete(); ens_seen.delete();
  endtask

  bit tgt [N];

  initial begin
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    chk("rst_obj_idx", 32'(obj_idx), 32'd0);
    chk("rst_map", 32'(inside_map), 32'h00);
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Entry of object 2 after three consecutive inside results.
    round(8'h04, 1'b1);
    round(8'h04, 1'b1);
    for (int k = 0; k < N; k++) begin
      cyc(1'b0, 1'b1, k == 2, 1'b1);
      if (k == 2) begin
        chk("entry_valid", 32'(evt_valid), 32'd1);
        chk("entry_id", 32'(evt_id), 32'd2);
        chk("entry_enter", 32'(evt_enter), 32'd1);
        chk("entry_map", 32'(inside_map), 32'h04);
      end
    end
    chk("entry_count", 32'(ids_seen.size()), 32'd1);

    // Exit of object 2 after three consecutive outside results.
    round(8'h00, 1'b1);
    round(8'h00, 1'b1);
    round(8'h00, 1'b1);
    chk("exit_count", 32'(ids_seen.size()), 32'd2);
    chk("exit_id", 32'(ids_seen[1]), 32'd2);
    chk("exit_enter", 32'(ens_seen[1]), 32'd0);
    chk("exit_map", 32'(inside_map), 32'h00);

    // Glitch filter on object 5: in, out, in, in -> nothing; one more in -> enter.
    do_reset();
    round(8'h20, 1'b1);
    round(8'h00, 1'b1);
    round(8'h20, 1'b1);
    round(8'h20, 1'b1);
    chk("glitch_none", 32'(ids_seen.size()), 32'd0);
    chk("glitch_map", 32'(inside_map), 32'h00);
    round(8'h20, 1'b1);
    chk("glitch_count", 32'(ids_seen.size()), 32'd1);
    chk("glitch_id", 32'(ids_seen[0]), 32'd5);
    chk("glitch_enter", 32'(ens_seen[0]), 32'd1);
    chk("glitch_map2", 32'(inside_map), 32'h20);

    // Backpressure: five entries into a four-deep FIFO.
    do_reset();
    repeat (3) round(8'h1F, 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_map", 32'(inside_map), 32'h1F);
    chk("ovf_head", 32'(evt_id), 32'd0);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("drain_count", 32'(ids_seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < ids_seen.size(); i++)
      chk("drain_order", 32'(ids_seen[i]), 32'(i));
    chk("drain_empty", 32'(evt_valid), 32'd0);

    // Full FIFO with a simultaneous pop and push for object 6.
    do_reset();
    repeat (2) round(8'h4F, 1'b0);
    for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, (8'h4F >> k) & 1, k == 6);
    chk("fpp_overflow", 32'(overflow), 32'd0);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fpp_count", 32'(ids_seen.size()), 32'd5);
    if (ids_seen.size() == 5) begin
      chk("fpp_id0", 32'(ids_seen[0]), 32'd0);
      chk("fpp_id4", 32'(ids_seen[4]), 32'd6);
    end

    // Random traffic with a mid-stream reset.
    do_reset();
    for (int i = 0; i < N; i++) tgt[i] = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (t == 1500) begin
        do_reset();
        chk("mid_rst_idx", 32'(obj_idx), 32'd0);
        chk("mid_rst_map", 32'(inside_map), 32'h00);
        chk("mid_rst_valid", 32'(evt_valid), 32'd0);
        chk("mid_rst_ovf", 32'(overflow), 32'd0);
      end
      if ($urandom_range(0, 15) == 0) tgt[m_idx] = ~tgt[m_idx];
      cyc(1'b0, $urandom_range(0, 3) != 0,
          ($urandom_range(0, 9) < 8) ? tgt[m_idx] : ~tgt[m_idx],
          $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
